// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between the CPU memory
// port and an external loader/debug port. One access is outstanding at a time.
// Every handshake output is registered; request inputs never reach a grant
// through combinational logic.
module mem_arbiter #(
  parameter int unsigned AW      = 5,
  parameter int unsigned DW      = 8,
  parameter int unsigned MEM_LAT = 1   // 1..3 cycles from mem_en to mem_rdata
) (
  input  logic          clk,
  input  logic          rst,
  // CPU controller port
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdata,
  // External loader/debug port
  input  logic          ext_req,
  input  logic          ext_we,
  input  logic [AW-1:0] ext_addr,
  input  logic [DW-1:0] ext_wdata,
  output logic          ext_gnt,
  output logic          ext_rvalid,
  output logic [DW-1:0] ext_rdata,
  // Memory macro
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  localparam logic [1:0] LatInit = 2'(MEM_LAT);

  state_e        state_q;
  logic          win_ext_q;    // winner of the access in flight
  logic          last_ext_q;   // last granted port, 1 = ext
  logic          we_q;
  logic [1:0]    cnt_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] cpu_rdata_q, ext_rdata_q;
  logic          cpu_gnt_q, ext_gnt_q, cpu_rvalid_q, ext_rvalid_q;
  logic          mem_en_q, mem_we_q;

  logic          pick_ext;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;

  // Winner select: a lone requester wins, a tie goes to the port not granted last.
  always_comb begin
    pick_ext  = ext_req && (!cpu_req || !last_ext_q);
    sel_we    = pick_ext ? ext_we    : cpu_we;
    sel_addr  = pick_ext ? ext_addr  : cpu_addr;
    sel_wdata = pick_ext ? ext_wdata : cpu_wdata;
  end

  // Access FSM; strobes default low so they only pulse for one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      win_ext_q    <= 1'b0;
      last_ext_q   <= 1'b1;  // CPU wins the first tie
      we_q         <= 1'b0;
      cnt_q        <= 2'd0;
      addr_q       <= '0;
      wdata_q      <= '0;
      cpu_rdata_q  <= '0;
      ext_rdata_q  <= '0;
      cpu_gnt_q    <= 1'b0;
      ext_gnt_q    <= 1'b0;
      cpu_rvalid_q <= 1'b0;
      ext_rvalid_q <= 1'b0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
    end else begin
      cpu_gnt_q    <= 1'b0;
      ext_gnt_q    <= 1'b0;
      cpu_rvalid_q <= 1'b0;
      ext_rvalid_q <= 1'b0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (cpu_req || ext_req) begin
            win_ext_q <= pick_ext;
            we_q      <= sel_we;
            addr_q    <= sel_addr;
            wdata_q   <= sel_wdata;
            mem_en_q  <= 1'b1;
            mem_we_q  <= sel_we;
            cpu_gnt_q <= !pick_ext;
            ext_gnt_q <= pick_ext;
            state_q   <= StIssue;
          end
        end
        StIssue: begin
          last_ext_q <= win_ext_q;
          if (we_q) begin
            state_q <= StIdle;
          end else begin
            cnt_q   <= LatInit;
            state_q <= StWait;
          end
        end
        StWait: begin
          if (cnt_q == 2'd1) begin
            if (win_ext_q) begin
              ext_rdata_q  <= mem_rdata;
              ext_rvalid_q <= 1'b1;
            end else begin
              cpu_rdata_q  <= mem_rdata;
              cpu_rvalid_q <= 1'b1;
            end
            state_q <= StResp;
          end else begin
            cnt_q <= cnt_q - 2'd1;
          end
        end
        StResp: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // Outputs come straight from registers.
  always_comb begin
    cpu_gnt    = cpu_gnt_q;
    ext_gnt    = ext_gnt_q;
    cpu_rvalid = cpu_rvalid_q;
    ext_rvalid = ext_rvalid_q;
    cpu_rdata  = cpu_rdata_q;
    ext_rdata  = ext_rdata_q;
    mem_en     = mem_en_q;
    mem_we     = mem_we_q;
    mem_addr   = addr_q;
    mem_wdata  = wdata_q;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: three instances (MEM_LAT = 1, 2, 3) share stimulus,
// each with its own memory model. Lane P (MEM_LAT = 2) is the main subject.
module tb_mem_arbiter;

  localparam int P    = 1;
  localparam int LatP = 2;

  typedef struct {
    bit         ext;
    bit         we;
    logic [4:0] addr;
    logic [7:0] wdata;
  } gnt_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       cpu_req, cpu_we, ext_req, ext_we;
  logic [4:0] cpu_addr, ext_addr;
  logic [7:0] cpu_wdata, ext_wdata;

  logic       cpu_gnt_a [3];
  logic       cpu_rvalid_a [3];
  logic [7:0] cpu_rdata_a [3];
  logic       ext_gnt_a [3];
  logic       ext_rvalid_a [3];
  logic [7:0] ext_rdata_a [3];
  logic       mem_en_a [3];
  logic       mem_we_a [3];
  logic [4:0] mem_addr_a [3];
  logic [7:0] mem_wdata_a [3];
  logic [7:0] mem_rdata_a [3];

  int checks = 0;
  int errors = 0;

  gnt_t       gnt_q[$];
  logic [7:0] cpu_rd_q[$];
  logic [7:0] ext_rd_q[$];
  logic [7:0] lane_rd_q[$];

  always #5 clk = ~clk;

  function automatic logic [7:0] init_val(input int a);
    if (a == 31) return 8'h3C;
    return 8'((a * 17 + 3) & 255);
  endfunction

  function automatic gnt_t mk_gnt(input bit ext, input bit we, input logic [4:0] addr,
                                  input logic [7:0] wdata);
    gnt_t e;
    e.ext = ext; e.we = we; e.addr = addr; e.wdata = wdata;
    return e;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_lat
    logic [7:0] mem [32];
    logic       wr  [32];
    logic [7:0] pipe [3];

    mem_arbiter #(.AW(5), .DW(8), .MEM_LAT(g + 1)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .cpu_req   (cpu_req),
      .cpu_we    (cpu_we),
      .cpu_addr  (cpu_addr),
      .cpu_wdata (cpu_wdata),
      .cpu_gnt   (cpu_gnt_a[g]),
      .cpu_rvalid(cpu_rvalid_a[g]),
      .cpu_rdata (cpu_rdata_a[g]),
      .ext_req   (ext_req),
      .ext_we    (ext_we),
      .ext_addr  (ext_addr),
      .ext_wdata (ext_wdata),
      .ext_gnt   (ext_gnt_a[g]),
      .ext_rvalid(ext_rvalid_a[g]),
      .ext_rdata (ext_rdata_a[g]),
      .mem_en    (mem_en_a[g]),
      .mem_we    (mem_we_a[g]),
      .mem_addr  (mem_addr_a[g]),
      .mem_wdata (mem_wdata_a[g]),
      .mem_rdata (mem_rdata_a[g])
    );

    // Memory model: read data appears g+1 cycles after the mem_en cycle, 0xEE otherwise.
    always @(posedge clk) begin
      if (mem_en_a[g] && mem_we_a[g]) begin
        mem[mem_addr_a[g]] <= mem_wdata_a[g];
        wr[mem_addr_a[g]]  <= 1'b1;
      end
      if (mem_en_a[g] && !mem_we_a[g])
        pipe[0] <= (wr[mem_addr_a[g]] === 1'b1) ? mem[mem_addr_a[g]] : init_val(int'(mem_addr_a[g]));
      else
        pipe[0] <= 8'hEE;
      pipe[1] <= pipe[0];
      pipe[2] <= pipe[1];
    end
    assign mem_rdata_a[g] = pipe[g];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    ext_req = 0; ext_we = 0; ext_addr = '0; ext_wdata = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    gnt_q.delete(); cpu_rd_q.delete(); ext_rd_q.delete(); lane_rd_q.delete();
    rst = 1; tick(); tick();
    rst = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1; tick(); tick();
    @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      checks++;
      if ({cpu_gnt_a[g], cpu_rvalid_a[g], ext_gnt_a[g], ext_rvalid_a[g], mem_en_a[g], mem_we_a[g],
           mem_addr_a[g], mem_wdata_a[g], cpu_rdata_a[g], ext_rdata_a[g]} !== '0) begin
        errors++;
        $display("FAIL reset_state lane %0d: outputs not all zero (mem_en=%b addr=%h)", g,
                 mem_en_a[g], mem_addr_a[g]);
      end
    end
    tick(); rst = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      checks++;
      if ({cpu_gnt_a[P], cpu_rvalid_a[P], ext_gnt_a[P], ext_rvalid_a[P], mem_en_a[P], mem_we_a[P],
           mem_addr_a[P], mem_wdata_a[P], cpu_rdata_a[P], ext_rdata_a[P]} !== '0) begin
        errors++;
        $display("FAIL idle_quiet cycle %0d: got mem_en=%b gnt=%b/%b, required all zero", k,
                 mem_en_a[P], cpu_gnt_a[P], ext_gnt_a[P]);
      end
      tick();
    end
  endtask

  task automatic test_cpu_write();
    gnt_t e;
    do_reset();
    cpu_req = 1; cpu_we = 1; cpu_addr = 5'h05; cpu_wdata = 8'hA3;
    gnt_q.push_back(mk_gnt(0, 1, 5'h05, 8'hA3));
    @(negedge clk);
    checks++;
    if (cpu_gnt_a[P] !== 1'b0 || mem_en_a[P] !== 1'b0) begin
      errors++;
      $display("FAIL write_no_early_gnt: got gnt=%b mem_en=%b, required 0/0", cpu_gnt_a[P],
               mem_en_a[P]);
    end
    for (int n = 0; n < 2; n++) begin
      tick();
      @(negedge clk);
      checks++;
      if ({cpu_gnt_a[P], ext_gnt_a[P], mem_en_a[P], mem_we_a[P]} !== 4'b1011) begin
        errors++;
        $display("FAIL write_issue %0d: got cpu_gnt,ext_gnt,en,we=%b%b%b%b, required 1011", n,
                 cpu_gnt_a[P], ext_gnt_a[P], mem_en_a[P], mem_we_a[P]);
      end
      if (gnt_q.size() != 0) begin
        e = gnt_q.pop_front();
        checks++;
        if (mem_addr_a[P] !== e.addr || mem_wdata_a[P] !== e.wdata) begin
          errors++;
          $display("FAIL write_data %0d: got addr=%h wdata=%h, required %h/%h", n, mem_addr_a[P],
                   mem_wdata_a[P], e.addr, e.wdata);
        end
      end
      tick();
      if (n == 0) begin
        // Second write presented in the cycle the FSM should be back in IDLE.
        cpu_addr = 5'h06; cpu_wdata = 8'h5C;
        gnt_q.push_back(mk_gnt(0, 1, 5'h06, 8'h5C));
      end else begin
        cpu_req = 0;
      end
      @(negedge clk);
      checks++;
      if (cpu_gnt_a[P] !== 1'b0 || mem_en_a[P] !== 1'b0 || mem_we_a[P] !== 1'b0 ||
          mem_addr_a[P] !== (n == 0 ? 5'h05 : 5'h06)) begin
        errors++;
        $display("FAIL write_idle %0d: got gnt=%b en=%b we=%b addr=%h, required 0/0/0 held", n,
                 cpu_gnt_a[P], mem_en_a[P], mem_we_a[P], mem_addr_a[P]);
      end
    end
    checks++;
    if (gnt_q.size() != 0) begin
      errors++;
      $display("FAIL write_scoreboard: got %0d grants missing, required 0", gnt_q.size());
    end
  endtask

  task automatic test_ext_read();
    logic [7:0] x;
    do_reset();
    ext_req = 1; ext_we = 0; ext_addr = 5'h1F;
    for (int g = 0; g < 3; g++) lane_rd_q.push_back(8'h3C);
    for (int k = 0; k <= 6; k++) begin
      @(negedge clk);
      for (int g = 0; g < 3; g++) begin
        checks++;
        if (ext_rvalid_a[g] !== (k == 3 + g) || cpu_rvalid_a[g] !== 1'b0 ||
            ext_gnt_a[g] !== (k == 1)) begin
          errors++;
          $display("FAIL ext_read_timing lat %0d cycle %0d: got gnt=%b rvalid=%b cpu_rvalid=%b",
                   g + 1, k, ext_gnt_a[g], ext_rvalid_a[g], cpu_rvalid_a[g]);
        end
        if (ext_rvalid_a[g] === 1'b1 && lane_rd_q.size() != 0) begin
          x = lane_rd_q.pop_front();
          checks++;
          if (ext_rdata_a[g] !== x) begin
            errors++;
            $display("FAIL ext_read_data lat %0d: got %h, required %h", g + 1, ext_rdata_a[g], x);
          end
        end
      end
      tick();
      if (k == 1) ext_req = 0;
    end
    checks++;
    if (lane_rd_q.size() != 0 || cpu_rdata_a[P] !== 8'h00) begin
      errors++;
      $display("FAIL ext_read_done: got %0d responses missing, cpu_rdata=%h, required 0/00",
               lane_rd_q.size(), cpu_rdata_a[P]);
    end
  endtask

  task automatic test_fairness();
    gnt_t e;
    logic [7:0] x;
    int ci = 0, ei = 0, ngnt = 0, nrv = 0, last_gnt = -1;
    bit got_c, got_e;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      gnt_q.push_back(mk_gnt(0, 0, 5'(i), 8'h00));
      gnt_q.push_back(mk_gnt(1, 0, 5'(16 + i), 8'h00));
    end
    cpu_req = 1; cpu_we = 0; cpu_addr = 5'd0;  cpu_rd_q.push_back(init_val(0));
    ext_req = 1; ext_we = 0; ext_addr = 5'd16; ext_rd_q.push_back(init_val(16));
    for (int cyc = 0; cyc < 80 && (ngnt < 6 || nrv < 6); cyc++) begin
      @(negedge clk);
      got_c = cpu_gnt_a[P];
      got_e = ext_gnt_a[P];
      if (got_c || got_e) begin
        checks++;
        if (gnt_q.size() == 0) begin
          errors++;
          $display("FAIL fair_extra_grant cycle %0d: got cpu=%b ext=%b, required none", cyc,
                   got_c, got_e);
        end else begin
          e = gnt_q.pop_front();
          if ({got_e, got_c} !== {e.ext, !e.ext} || mem_addr_a[P] !== e.addr ||
              mem_we_a[P] !== e.we) begin
            errors++;
            $display("FAIL fair_order grant %0d: got ext=%b cpu=%b addr=%h, required ext=%b addr=%h",
                     ngnt, got_e, got_c, mem_addr_a[P], e.ext, e.addr);
          end
        end
        if (last_gnt >= 0) begin
          checks++;
          if (cyc - last_gnt != LatP + 3) begin
            errors++;
            $display("FAIL fair_gap grant %0d: got %0d cycles, required %0d", ngnt,
                     cyc - last_gnt, LatP + 3);
          end
        end
        last_gnt = cyc;
        ngnt++;
      end
      if (cpu_rvalid_a[P] === 1'b1) begin
        checks++; nrv++;
        x = (cpu_rd_q.size() != 0) ? cpu_rd_q.pop_front() : 8'hxx;
        if (cpu_rdata_a[P] !== x || ext_rvalid_a[P] !== 1'b0) begin
          errors++;
          $display("FAIL fair_cpu_rdata: got %h, required %h", cpu_rdata_a[P], x);
        end
      end
      if (ext_rvalid_a[P] === 1'b1) begin
        checks++; nrv++;
        x = (ext_rd_q.size() != 0) ? ext_rd_q.pop_front() : 8'hxx;
        if (ext_rdata_a[P] !== x) begin
          errors++;
          $display("FAIL fair_ext_rdata: got %h, required %h", ext_rdata_a[P], x);
        end
      end
      tick();
      if (got_c) begin
        ci++;
        if (ci < 3) begin cpu_addr = 5'(ci); cpu_rd_q.push_back(init_val(ci)); end
        else cpu_req = 0;
      end
      if (got_e) begin
        ei++;
        if (ei < 3) begin ext_addr = 5'(16 + ei); ext_rd_q.push_back(init_val(16 + ei)); end
        else ext_req = 0;
      end
    end
    checks++;
    if (ngnt != 6 || nrv != 6) begin
      errors++;
      $display("FAIL fair_count: got %0d grants %0d responses, required 6/6", ngnt, nrv);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] x;
    bit seen;
    do_reset();
    // First read completes so cpu_rdata holds a non-zero value.
    cpu_req = 1; cpu_we = 0; cpu_addr = 5'd0; cpu_rd_q.push_back(init_val(0));
    @(negedge clk); tick();
    @(negedge clk);
    tick(); cpu_req = 0;
    seen = 0;
    for (int n = 0; n < 8 && !seen; n++) begin
      @(negedge clk);
      if (cpu_rvalid_a[P] === 1'b1) begin
        seen = 1;
        x = cpu_rd_q.pop_front();
        checks++;
        if (cpu_rdata_a[P] !== x) begin
          errors++;
          $display("FAIL rstmid_first_read: got %h, required %h", cpu_rdata_a[P], x);
        end
      end
      tick();
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL rstmid_first_timeout: got no cpu_rvalid, required one");
    end
    // Second read, interrupted by reset in its first WAIT cycle.
    tick();
    cpu_req = 1; cpu_addr = 5'd1;
    @(negedge clk); tick();
    @(negedge clk);
    checks++;
    if (cpu_gnt_a[P] !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_gnt: got %b, required 1", cpu_gnt_a[P]);
    end
    tick();
    cpu_req = 0; rst = 1;
    ext_req = 1; ext_we = 0; ext_addr = 5'h1F; ext_rd_q.push_back(8'h3C);
    @(negedge clk); tick();
    rst = 0;
    @(negedge clk);
    checks++;
    if (cpu_rvalid_a[P] !== 1'b0 || cpu_rdata_a[P] !== 8'h00 || mem_en_a[P] !== 1'b0 ||
        ext_gnt_a[P] !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_cleared: got rvalid=%b rdata=%h en=%b, required 0/00/0",
               cpu_rvalid_a[P], cpu_rdata_a[P], mem_en_a[P]);
    end
    tick();
    @(negedge clk);
    checks++;
    if (ext_gnt_a[P] !== 1'b1 || mem_addr_a[P] !== 5'h1F) begin
      errors++;
      $display("FAIL rstmid_ext_gnt: got gnt=%b addr=%h, required 1/1f", ext_gnt_a[P],
               mem_addr_a[P]);
    end
    tick(); ext_req = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (cpu_rvalid_a[P] !== 1'b0 || ext_rvalid_a[P] !== (k == LatP)) begin
        errors++;
        $display("FAIL rstmid_resp cycle %0d: got cpu_rvalid=%b ext_rvalid=%b", k,
                 cpu_rvalid_a[P], ext_rvalid_a[P]);
      end
      if (ext_rvalid_a[P] === 1'b1 && ext_rd_q.size() != 0) begin
        x = ext_rd_q.pop_front();
        checks++;
        if (ext_rdata_a[P] !== x) begin
          errors++;
          $display("FAIL rstmid_ext_data: got %h, required %h", ext_rdata_a[P], x);
        end
      end
      tick();
    end
  endtask

  task automatic test_wait_request();
    gnt_t e;
    logic [7:0] x;
    do_reset();
    ext_req = 1; ext_we = 0; ext_addr = 5'h1F; ext_rd_q.push_back(8'h3C);
    for (int k = 0; k <= 8; k++) begin
      @(negedge clk);
      checks++;
      if (ext_rvalid_a[P] !== (k == 2 + LatP) || cpu_gnt_a[P] !== (k == 4 + LatP)) begin
        errors++;
        $display("FAIL waitreq_timing cycle %0d: got ext_rvalid=%b cpu_gnt=%b", k,
                 ext_rvalid_a[P], cpu_gnt_a[P]);
      end
      if (ext_rvalid_a[P] === 1'b1 && ext_rd_q.size() != 0) begin
        x = ext_rd_q.pop_front();
        checks++;
        if (ext_rdata_a[P] !== x) begin
          errors++;
          $display("FAIL waitreq_ext_data: got %h, required %h", ext_rdata_a[P], x);
        end
      end
      if (cpu_gnt_a[P] === 1'b1 && gnt_q.size() != 0) begin
        e = gnt_q.pop_front();
        checks++;
        if (mem_addr_a[P] !== e.addr || mem_we_a[P] !== e.we || mem_wdata_a[P] !== e.wdata) begin
          errors++;
          $display("FAIL waitreq_capture: got addr=%h we=%b wdata=%h, required %h/%b/%h",
                   mem_addr_a[P], mem_we_a[P], mem_wdata_a[P], e.addr, e.we, e.wdata);
        end
      end
      tick();
      if (cpu_gnt_a[P] === 1'b1) cpu_req = 0;
      if (k == 1) begin
        // Arrives during the ext read's WAIT phase.
        ext_req = 0;
        cpu_req = 1; cpu_we = 1; cpu_addr = 5'h0A; cpu_wdata = 8'h77;
        gnt_q.push_back(mk_gnt(0, 1, 5'h0A, 8'h77));
      end
    end
    checks++;
    if (gnt_q.size() != 0 || ext_rd_q.size() != 0) begin
      errors++;
      $display("FAIL waitreq_done: got %0d grants %0d responses outstanding, required 0/0",
               gnt_q.size(), ext_rd_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_cpu_write();
    test_ext_read();
    test_fairness();
    test_reset_mid();
    test_wait_request();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
